// File: rtl/multicycle_datapath.sv
// Multicycle RISC-V datapath: one instruction per IF/ID/EX/(MEM)/WB sequence, with
// architectural stage registers and a req/ready data-memory handshake.
module multicycle_datapath #(
    parameter logic [31:0] INITIAL_PC = 32'h00400000,
    parameter int unsigned XLEN       = 32,
    parameter int unsigned NREGS      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    output logic [31:0]     IR,
    input  logic            ALUSrc,
    input  logic            RegWrite,
    input  logic            MemToReg,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            PCSrc,
    input  logic [3:0]      ALUCtrl,
    input  logic [XLEN-1:0] dReadData,
    input  logic            dReady,
    output logic [31:0]     PC,
    output logic            Zero,
    output logic [XLEN-1:0] dAddress,
    output logic [XLEN-1:0] dWriteData,
    output logic            dReq,
    output logic            dWe,
    output logic [XLEN-1:0] WriteBackData,
    output logic            instrDone,
    output logic [2:0]      state
);

    localparam int unsigned RegAw = $clog2(NREGS);
    localparam int unsigned ShW   = $clog2(XLEN);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q;
    logic [31:0]       ir_q;
    logic [XLEN-1:0]   a_q, b_q, imm_q, alu_q, mdr_q;
    logic              zero_q;
    logic [XLEN-1:0]   rf_q [NREGS];

    logic [RegAw-1:0]  rs1_idx, rs2_idx, rd_idx;
    logic [XLEN-1:0]   rs1_val, rs2_val;
    logic [XLEN-1:0]   imm_d;
    logic [XLEN-1:0]   op2;
    logic [ShW-1:0]    shamt;
    logic signed [XLEN-1:0] a_s;
    logic [XLEN-1:0]   alu_res;
    logic              rf_we;
    logic              unused_funct3;

    // funct3 is decoded externally; the datapath never looks at it.
    assign unused_funct3 = ^ir_q[14:12];

    assign rs1_idx = ir_q[15 +: RegAw];
    assign rs2_idx = ir_q[20 +: RegAw];
    assign rd_idx  = ir_q[7 +: RegAw];

    assign rs1_val = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    assign rs2_val = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

    always_comb begin
        imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
        case (ir_q[6:0])
            7'b0100011: imm_d = {{(XLEN-12){ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011: imm_d = {{(XLEN-13){ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25],
                                 ir_q[11:8], 1'b0};
            default: ;
        endcase
    end

    assign op2   = ALUSrc ? imm_q : b_q;
    assign shamt = op2[ShW-1:0];
    assign a_s   = a_q;

    always_comb begin
        alu_res = '0;
        case (ALUCtrl)
            4'b0000: alu_res = a_q & op2;
            4'b0001: alu_res = a_q | op2;
            4'b0010: alu_res = a_q + op2;
            4'b0110: alu_res = a_q - op2;
            4'b0111: alu_res = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op2))};
            4'b1101: alu_res = a_q ^ op2;
            4'b1000: alu_res = a_q >> shamt;
            4'b1001: alu_res = a_q << shamt;
            4'b1010: alu_res = a_s >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIf:    state_d = StId;
            StId:    state_d = StEx;
            StEx:    state_d = (MemRead || MemWrite) ? StMem : StWb;
            StMem:   if (dReady) state_d = StWb;
            StWb:    state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIf;
            pc_q    <= INITIAL_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            imm_q   <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIf: ir_q <= instr;
                StId: begin
                    a_q   <= rs1_val;
                    b_q   <= rs2_val;
                    imm_q <= imm_d;
                end
                StEx: begin
                    alu_q  <= alu_res;
                    zero_q <= (alu_res == '0);
                end
                StMem: if (dReady && MemRead) mdr_q <= dReadData;
                StWb:  pc_q <= PCSrc ? pc_q + imm_q[31:0] : pc_q + 32'd4;
                default: ;
            endcase
        end
    end

    assign rf_we = (state_q == StWb) && RegWrite && (rd_idx != '0);

    // x0 is never written, so its entry stays at its reset value of zero.
    for (genvar g = 0; g < NREGS; g++) begin : g_rf
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rf_q[g] <= '0;
            end else if (rf_we && (rd_idx == RegAw'(g))) begin
                rf_q[g] <= WriteBackData;
            end
        end
    end

    assign IR            = ir_q;
    assign PC            = pc_q;
    assign Zero          = zero_q;
    assign dAddress      = alu_q;
    assign dWriteData    = b_q;
    assign dReq          = (state_q == StMem);
    assign dWe           = dReq && MemWrite;
    assign WriteBackData = MemToReg ? mdr_q : alu_q;
    assign instrDone     = (state_q == StWb);
    assign state         = state_q;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: a default 32-bit instance and a
// 64-bit / 16-register instance, each checked against hand-computed results.
module tb_multicycle_datapath;

    localparam logic [31:0] InitPc = 32'h00400000;

    localparam logic [3:0] OpAnd = 4'b0000, OpAdd = 4'b0010, OpSub = 4'b0110,
                           OpSlt = 4'b0111, OpXor = 4'b1101, OpSrl = 4'b1000,
                           OpSll = 4'b1001, OpSra = 4'b1010, OpBad = 4'b0011;

    // {ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, PCSrc}
    localparam logic [5:0] CNone = 6'b000000, CAluI = 6'b110000, CAluR = 6'b010000,
                           CStore = 6'b100010, CLoad = 6'b111100, CBr = 6'b000001;

    logic        clk = 1'b0;
    logic        rst, rst_w;

    // 32-bit instance signals
    logic [31:0] instr, ir;
    logic        alu_src, reg_write, mem_to_reg, mem_read, mem_write, pc_src;
    logic [3:0]  alu_ctrl;
    logic [31:0] d_read_data, d_address, d_write_data, write_back_data, pc;
    logic        d_ready, zero, d_req, d_we, instr_done;
    logic [2:0]  state;

    // 64-bit instance signals
    logic [31:0] instr_w, ir_w, pc_w;
    logic        alu_src_w, reg_write_w, mem_to_reg_w, mem_read_w, mem_write_w, pc_src_w;
    logic [3:0]  alu_ctrl_w;
    logic [63:0] d_read_data_w, d_address_w, d_write_data_w, write_back_data_w;
    logic        d_ready_w, zero_w, d_req_w, d_we_w, instr_done_w;
    logic [2:0]  state_w;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc, req_cyc, cyc_w;
    logic        we_seen;
    logic [31:0] addr_seen, wdata_seen, wb_seen;
    logic [63:0] wb_seen_w;

    always #5 clk = ~clk;

    multicycle_datapath dut (
        .clk(clk), .rst(rst), .instr(instr), .IR(ir),
        .ALUSrc(alu_src), .RegWrite(reg_write), .MemToReg(mem_to_reg),
        .MemRead(mem_read), .MemWrite(mem_write), .PCSrc(pc_src), .ALUCtrl(alu_ctrl),
        .dReadData(d_read_data), .dReady(d_ready), .PC(pc), .Zero(zero),
        .dAddress(d_address), .dWriteData(d_write_data), .dReq(d_req), .dWe(d_we),
        .WriteBackData(write_back_data), .instrDone(instr_done), .state(state)
    );

    multicycle_datapath #(.INITIAL_PC(InitPc), .XLEN(64), .NREGS(16)) dut_w (
        .clk(clk), .rst(rst_w), .instr(instr_w), .IR(ir_w),
        .ALUSrc(alu_src_w), .RegWrite(reg_write_w), .MemToReg(mem_to_reg_w),
        .MemRead(mem_read_w), .MemWrite(mem_write_w), .PCSrc(pc_src_w),
        .ALUCtrl(alu_ctrl_w), .dReadData(d_read_data_w), .dReady(d_ready_w), .PC(pc_w),
        .Zero(zero_w), .dAddress(d_address_w), .dWriteData(d_write_data_w),
        .dReq(d_req_w), .dWe(d_we_w), .WriteBackData(write_back_data_w),
        .instrDone(instr_done_w), .state(state_w)
    );

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [4:0] rd);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {imm, rs1, 3'b000, rd, opc};
    endfunction

    // Runs one instruction on the 32-bit instance from IF to the edge after WB.
    task automatic exec32(input logic [31:0] ins, input logic [3:0] op, input logic [5:0] c,
                          input int waits, input logic [31:0] rdata);
        bit done = 0;
        instr = ins;
        alu_ctrl = op;
        {alu_src, reg_write, mem_to_reg, mem_read, mem_write, pc_src} = c;
        d_read_data = rdata;
        d_ready = 1'b0;
        cyc = 0;
        req_cyc = 0;
        we_seen = 1'b0;
        wb_seen = '0;
        while (!done && cyc < 64) begin
            cyc++;
            if (d_req) begin
                req_cyc++;
                we_seen |= d_we;
                addr_seen = d_address;
                wdata_seen = d_write_data;
            end
            d_ready = d_req && (req_cyc > waits);
            if (instr_done) begin
                done = 1;
                wb_seen = write_back_data;
            end
            @(negedge clk);
        end
        d_ready = 1'b0;
    endtask

    task automatic exec64(input logic [31:0] ins, input logic [3:0] op, input logic [5:0] c);
        bit done = 0;
        instr_w = ins;
        alu_ctrl_w = op;
        {alu_src_w, reg_write_w, mem_to_reg_w, mem_read_w, mem_write_w, pc_src_w} = c;
        cyc_w = 0;
        wb_seen_w = '0;
        while (!done && cyc_w < 64) begin
            cyc_w++;
            if (instr_done_w) begin
                done = 1;
                wb_seen_w = write_back_data_w;
            end
            @(negedge clk);
        end
    endtask

    // Reads xN by executing add x0, xN, x0 and sampling WriteBackData.
    task automatic read32(input logic [4:0] n);
        exec32(r_type(7'd0, 5'd0, n, 5'd0), OpAdd, CNone, 0, 32'd0);
    endtask

    task automatic apply_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        instr = 32'h00A00293;
        alu_ctrl = OpAnd;
        {alu_src, reg_write, mem_to_reg, mem_read, mem_write, pc_src} = CNone;
        d_read_data = 32'hDEADBEEF;
        d_ready = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (pc !== InitPc) begin miscompares++; $display("FAIL rst_pc: got %h want %h", pc, InitPc); end
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL rst_state: got %0d want 0", state); end
        vectors++; if (ir !== 32'd0) begin miscompares++; $display("FAIL rst_ir: got %h want 0", ir); end
        vectors++; if ({d_req, d_we, instr_done, zero} !== 4'b0) begin miscompares++; $display("FAIL rst_flags: got %b want 0000", {d_req, d_we, instr_done, zero}); end
        vectors++; if (d_address !== 32'd0) begin miscompares++; $display("FAIL rst_daddr: got %h want 0", d_address); end
        vectors++; if (d_write_data !== 32'd0) begin miscompares++; $display("FAIL rst_dwdata: got %h want 0", d_write_data); end
        vectors++; if (write_back_data !== 32'd0) begin miscompares++; $display("FAIL rst_wb: got %h want 0", write_back_data); end
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (ir !== 32'h00A00293) begin miscompares++; $display("FAIL rel_ir: got %h want 00a00293", ir); end
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL rel_state: got %0d want 1", state); end
    endtask

    task automatic test_alu;
        apply_reset();
        exec32(i_type(12'hFFD, 5'd0, 5'd5, 7'b0010011), OpAdd, CAluI, 0, 32'd0);
        vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL addi_cycles: got %0d want 4", cyc); end
        vectors++; if (wb_seen !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL addi_wb: got %h want fffffffd", wb_seen); end
        vectors++; if (pc !== 32'h00400004) begin miscompares++; $display("FAIL addi_pc: got %h want 00400004", pc); end
        vectors++; if (zero !== 1'b0) begin miscompares++; $display("FAIL addi_zero: got %b want 0", zero); end
        read32(5'd5);
        vectors++; if (wb_seen !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL x5_read: got %h want fffffffd", wb_seen); end
        exec32(r_type(7'b0100000, 5'd5, 5'd5, 5'd6), OpSub, CAluR, 0, 32'd0);
        vectors++; if (zero !== 1'b1) begin miscompares++; $display("FAIL sub_zero: got %b want 1", zero); end
        vectors++; if (wb_seen !== 32'd0) begin miscompares++; $display("FAIL sub_wb: got %h want 0", wb_seen); end
        exec32(r_type(7'd0, 5'd0, 5'd5, 5'd8), OpSlt, CAluR, 0, 32'd0);
        vectors++; if (wb_seen !== 32'd1) begin miscompares++; $display("FAIL slt_wb: got %h want 1", wb_seen); end
        exec32(i_type(12'hFFF, 5'd5, 5'd9, 7'b0010011), OpXor, CAluI, 0, 32'd0);
        vectors++; if (wb_seen !== 32'd2) begin miscompares++; $display("FAIL xori_wb: got %h want 2", wb_seen); end
        exec32(i_type(12'd28, 5'd5, 5'd10, 7'b0010011), OpSrl, CAluI, 0, 32'd0);
        vectors++; if (wb_seen !== 32'hF) begin miscompares++; $display("FAIL srli_wb: got %h want f", wb_seen); end
        exec32(i_type(12'd0, 5'd5, 5'd0, 7'b0010011), OpBad, CAluI, 0, 32'd0);
        vectors++; if (wb_seen !== 32'd0) begin miscompares++; $display("FAIL badop_wb: got %h want 0", wb_seen); end
    endtask

    task automatic test_x0;
        exec32(i_type(12'd7, 5'd0, 5'd0, 7'b0010011), OpAdd, CAluI, 0, 32'd0);
        vectors++; if (wb_seen !== 32'd7) begin miscompares++; $display("FAIL x0_addi_wb: got %h want 7", wb_seen); end
        read32(5'd0);
        vectors++; if (wb_seen !== 32'd0) begin miscompares++; $display("FAIL x0_read: got %h want 0", wb_seen); end
    endtask

    task automatic test_mem;
        exec32({7'd0, 5'd5, 5'd0, 3'b010, 5'd8, 7'b0100011}, OpAdd, CStore, 3, 32'd0);
        vectors++; if (cyc !== 8) begin miscompares++; $display("FAIL sw_cycles: got %0d want 8", cyc); end
        vectors++; if (req_cyc !== 4) begin miscompares++; $display("FAIL sw_req_cycles: got %0d want 4", req_cyc); end
        vectors++; if (we_seen !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %b want 1", we_seen); end
        vectors++; if (addr_seen !== 32'd8) begin miscompares++; $display("FAIL sw_addr: got %h want 8", addr_seen); end
        vectors++; if (wdata_seen !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL sw_wdata: got %h want fffffffd", wdata_seen); end
        exec32({12'd8, 5'd0, 3'b010, 5'd7, 7'b0000011}, OpAdd, CLoad, 0, 32'hFFFFFFFD);
        vectors++; if (cyc !== 5) begin miscompares++; $display("FAIL lw_cycles: got %0d want 5", cyc); end
        vectors++; if (we_seen !== 1'b0) begin miscompares++; $display("FAIL lw_we: got %b want 0", we_seen); end
        vectors++; if (wb_seen !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL lw_wb: got %h want fffffffd", wb_seen); end
        read32(5'd7);
        vectors++; if (wb_seen !== 32'hFFFFFFFD) begin miscompares++; $display("FAIL x7_read: got %h want fffffffd", wb_seen); end
    endtask

    task automatic test_branch;
        logic [31:0] beq_m16;
        beq_m16 = {1'b1, 6'b111111, 5'd0, 5'd0, 3'b000, 4'b1000, 1'b1, 7'b1100011};
        apply_reset();
        repeat (4) exec32(i_type(12'd0, 5'd0, 5'd0, 7'b0010011), OpAdd, CNone, 0, 32'd0);
        vectors++; if (pc !== 32'h00400010) begin miscompares++; $display("FAIL br_setup_pc: got %h want 00400010", pc); end
        exec32(beq_m16, OpSub, CBr, 0, 32'd0);
        vectors++; if (pc !== 32'h00400000) begin miscompares++; $display("FAIL br_taken_pc: got %h want 00400000", pc); end
        vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL br_cycles: got %0d want 4", cyc); end
        repeat (4) exec32(i_type(12'd0, 5'd0, 5'd0, 7'b0010011), OpAdd, CNone, 0, 32'd0);
        exec32(beq_m16, OpSub, CNone, 0, 32'd0);
        vectors++; if (pc !== 32'h00400014) begin miscompares++; $display("FAIL br_not_taken_pc: got %h want 00400014", pc); end
    endtask

    task automatic test_reset_mid_mem;
        apply_reset();
        exec32(i_type(12'hFFD, 5'd0, 5'd5, 7'b0010011), OpAdd, CAluI, 0, 32'd0);
        instr = {7'd0, 5'd5, 5'd0, 3'b010, 5'd8, 7'b0100011};
        alu_ctrl = OpAdd;
        {alu_src, reg_write, mem_to_reg, mem_read, mem_write, pc_src} = CStore;
        d_ready = 1'b0;
        for (int i = 0; i < 10 && !d_req; i++) @(negedge clk);
        vectors++; if (d_req !== 1'b1) begin miscompares++; $display("FAIL mid_mem_reach: got %b want 1", d_req); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        vectors++; if ({d_req, d_we} !== 2'b00) begin miscompares++; $display("FAIL mid_mem_req: got %b want 00", {d_req, d_we}); end
        vectors++; if (pc !== InitPc) begin miscompares++; $display("FAIL mid_mem_pc: got %h want %h", pc, InitPc); end
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL mid_mem_state: got %0d want 0", state); end
        @(negedge clk);
        rst = 1'b1;
        read32(5'd5);
        vectors++; if (wb_seen !== 32'd0) begin miscompares++; $display("FAIL mid_mem_x5: got %h want 0", wb_seen); end
    endtask

    task automatic test_wide;
        rst_w = 1'b0;
        repeat (3) @(negedge clk);
        rst_w = 1'b1;
        exec64(i_type(12'h123, 5'd0, 5'd17, 7'b0010011), OpAdd, CAluI);
        vectors++; if (cyc_w !== 4) begin miscompares++; $display("FAIL w_cycles: got %0d want 4", cyc_w); end
        exec64(r_type(7'd0, 5'd0, 5'd1, 5'd0), OpAdd, CNone);
        vectors++; if (wb_seen_w !== 64'h123) begin miscompares++; $display("FAIL w_x1_alias: got %h want 123", wb_seen_w); end
        exec64(r_type(7'd0, 5'd0, 5'd17, 5'd0), OpAdd, CNone);
        vectors++; if (wb_seen_w !== 64'h123) begin miscompares++; $display("FAIL w_x17_read: got %h want 123", wb_seen_w); end
        exec64(i_type(12'hFFF, 5'd0, 5'd2, 7'b0010011), OpAdd, CAluI);
        vectors++; if (wb_seen_w !== 64'hFFFFFFFFFFFFFFFF) begin miscompares++; $display("FAIL w_ones: got %h want all ones", wb_seen_w); end
        exec64(i_type(12'd63, 5'd2, 5'd3, 7'b0010011), OpSll, CAluI);
        vectors++; if (wb_seen_w !== 64'h8000000000000000) begin miscompares++; $display("FAIL w_slli: got %h want 8000000000000000", wb_seen_w); end
        exec64(i_type(12'h43F, 5'd3, 5'd4, 7'b0010011), OpSra, CAluI);
        vectors++; if (wb_seen_w !== 64'hFFFFFFFFFFFFFFFF) begin miscompares++; $display("FAIL w_srai: got %h want all ones", wb_seen_w); end
        exec64(i_type(12'd63, 5'd3, 5'd5, 7'b0010011), OpSrl, CAluI);
        vectors++; if (wb_seen_w !== 64'd1) begin miscompares++; $display("FAIL w_srli: got %h want 1", wb_seen_w); end
        exec64(r_type(7'd0, 5'd0, 5'd3, 5'd6), OpSlt, CAluR);
        vectors++; if (wb_seen_w !== 64'd1) begin miscompares++; $display("FAIL w_slt: got %h want 1", wb_seen_w); end
        exec64(i_type(12'd1, 5'd2, 5'd7, 7'b0010011), OpAdd, CAluI);
        vectors++; if (wb_seen_w !== 64'd0) begin miscompares++; $display("FAIL w_wrap: got %h want 0", wb_seen_w); end
        vectors++; if (zero_w !== 1'b1) begin miscompares++; $display("FAIL w_zero: got %b want 1", zero_w); end
        vectors++; if (pc_w !== 32'h00400024) begin miscompares++; $display("FAIL w_pc: got %h want 00400024", pc_w); end
    endtask

    initial begin
        rst_w = 1'b0;
        instr_w = '0;
        alu_ctrl_w = OpAdd;
        {alu_src_w, reg_write_w, mem_to_reg_w, mem_read_w, mem_write_w, pc_src_w} = CNone;
        d_read_data_w = '0;
        d_ready_w = 1'b0;
        test_reset();
        test_alu();
        test_x0();
        test_mem();
        test_branch();
        test_reset_mid_mem();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
